// File: rtl/latch_bank_if.sv
// Bus bundle for latch_bank: asynchronous write strobe/data/select in,
// per-channel consume strobes in, channel values and status flags out.
interface latch_bank_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SW = $clog2(CHANNELS);

  logic [WIDTH-1:0]          d;
  logic [SW-1:0]             sel;
  logic                      en;
  logic                      clr;
  logic [CHANNELS-1:0]       ack;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS-1:0]       upd;
  logic [CHANNELS-1:0]       pend;
  logic [CHANNELS-1:0]       ovf;

  modport master (
    output d, sel, en, clr, ack,
    input  q, upd, pend, ovf
  );

  modport slave (
    input  d, sel, en, clr, ack,
    output q, upd, pend, ovf
  );
endinterface

// File: rtl/latch_bank.sv
// Multi-channel capture register bank fed by an asynchronous strobe/data/select
// that is synchronised in lockstep; per-channel update/pending/overflow flags.
module latch_bank #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 1
) (
  input  logic         clk,
  input  logic         rstn,
  latch_bank_if.slave  bus
);
  localparam int SW = $clog2(CHANNELS);

  logic [SYNC_STAGES-1:0]            en_sync_q, en_sync_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] d_sync_q, d_sync_d;
  logic [SYNC_STAGES-1:0][SW-1:0]    sel_sync_q, sel_sync_d;
  logic                              en_d_q, en_d_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    q_q, q_d;
  logic [CHANNELS-1:0]               upd_q, upd_d;
  logic [CHANNELS-1:0]               pend_q, pend_d;
  logic [CHANNELS-1:0]               ovf_q, ovf_d;

  logic                en_s;
  logic [WIDTH-1:0]    d_s;
  logic [SW-1:0]       sel_s;
  logic                rise;
  logic                wr;
  logic [CHANNELS-1:0] wr_vec;

  always_comb begin
    // d and sel shift with en so the captured word always matches its strobe
    en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], bus.en};
    d_sync_d   = {d_sync_q[SYNC_STAGES-2:0], bus.d};
    sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], bus.sel};

    en_s   = en_sync_q[SYNC_STAGES-1];
    d_s    = d_sync_q[SYNC_STAGES-1];
    sel_s  = sel_sync_q[SYNC_STAGES-1];
    en_d_d = en_s;
    rise   = en_s & ~en_d_q;
    wr     = (MODE == 1) ? rise : en_s;

    // An out-of-range sel matches no channel, so the write disappears
    for (int i = 0; i < CHANNELS; i++) begin
      wr_vec[i] = wr & (sel_s == SW'(i));
    end

    q_d    = q_q;
    upd_d  = wr_vec;
    pend_d = (pend_q & ~bus.ack) | wr_vec;
    // Only the leading write of a burst may flag overflow
    ovf_d  = ovf_q | (wr_vec & pend_q & ~bus.ack & {CHANNELS{rise}});
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_vec[i]) begin
        q_d[i] = d_s;
      end
    end

    if (bus.clr) begin
      q_d    = '0;
      upd_d  = '0;
      pend_d = '0;
      ovf_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_sync_q  <= '0;
      d_sync_q   <= '0;
      sel_sync_q <= '0;
      en_d_q     <= 1'b0;
      q_q        <= '0;
      upd_q      <= '0;
      pend_q     <= '0;
      ovf_q      <= '0;
    end else begin
      en_sync_q  <= en_sync_d;
      d_sync_q   <= d_sync_d;
      sel_sync_q <= sel_sync_d;
      en_d_q     <= en_d_d;
      q_q        <= q_d;
      upd_q      <= upd_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.upd  = upd_q;
  assign bus.pend = pend_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_latch_bank.sv
// Bench for latch_bank: edge-mode, level-mode and a three-channel edge-mode
// instance share one stimulus stream and are compared against a sample-history model.
module tb_latch_bank;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] d = 8'h00;
  logic [1:0] sel = 2'd0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] ack = 4'h0;

  int nassert = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  latch_bank_if #(.WIDTH(8), .CHANNELS(4)) if0 ();
  latch_bank_if #(.WIDTH(8), .CHANNELS(4)) if1 ();
  latch_bank_if #(.WIDTH(8), .CHANNELS(3)) if2 ();

  assign if0.d = d;  assign if0.sel = sel;  assign if0.en = en;  assign if0.clr = clr;  assign if0.ack = ack;
  assign if1.d = d;  assign if1.sel = sel;  assign if1.en = en;  assign if1.clr = clr;  assign if1.ack = ack;
  assign if2.d = d;  assign if2.sel = sel;  assign if2.en = en;  assign if2.clr = clr;  assign if2.ack = ack[2:0];

  latch_bank #(.WIDTH(8), .CHANNELS(4), .SYNC_STAGES(2), .MODE(1)) dut0 (.clk(clk), .rstn(rstn), .bus(if0));
  latch_bank #(.WIDTH(8), .CHANNELS(4), .SYNC_STAGES(2), .MODE(0)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
  latch_bank #(.WIDTH(8), .CHANNELS(3), .SYNC_STAGES(2), .MODE(1)) dut2 (.clk(clk), .rstn(rstn), .bus(if2));

  // Reference: history of what was sampled at recent edges; index 0 is the previous edge
  logic       hen  [SS+1];
  logic [7:0] hd   [SS+1];
  logic [1:0] hsel [SS+1];
  logic [7:0] mq   [3][4];
  logic [3:0] mupd [3];
  logic [3:0] mpend[3];
  logic [3:0] movf [3];

  task automatic model_reset();
    for (int k = 0; k <= SS; k++) begin
      hen[k] = 1'b0; hd[k] = 8'h00; hsel[k] = 2'd0;
    end
    for (int m = 0; m < 3; m++) begin
      for (int c = 0; c < 4; c++) mq[m][c] = 8'h00;
      mupd[m] = 4'h0; mpend[m] = 4'h0; movf[m] = 4'h0;
    end
  endtask

  // Applies the rules for one rising edge using the inputs present at that edge
  task automatic model_step();
    logic s_en, p_en, rise_m, wr_m;
    int   nch, ch;
    if (!rstn) begin
      model_reset();
      return;
    end
    s_en   = hen[SS-1];
    p_en   = hen[SS];
    rise_m = s_en & ~p_en;
    for (int m = 0; m < 3; m++) begin
      nch  = (m == 2) ? 3 : 4;
      wr_m = (m == 1) ? s_en : rise_m;
      if (clr) begin
        for (int c = 0; c < 4; c++) mq[m][c] = 8'h00;
        mupd[m] = 4'h0; mpend[m] = 4'h0; movf[m] = 4'h0;
      end else begin
        mupd[m] = 4'h0;
        if (wr_m && int'(hsel[SS-1]) < nch) begin
          ch = int'(hsel[SS-1]);
          if (rise_m && mpend[m][ch] && !ack[ch]) movf[m][ch] = 1'b1;
          mpend[m] = mpend[m] & ~ack;
          mq[m][ch] = hd[SS-1];
          mupd[m][ch] = 1'b1;
          mpend[m][ch] = 1'b1;
        end else begin
          mpend[m] = mpend[m] & ~ack;
        end
        if (m == 2) mpend[m][3] = 1'b0;
      end
    end
    for (int k = SS; k > 0; k--) begin
      hen[k] = hen[k-1]; hd[k] = hd[k-1]; hsel[k] = hsel[k-1];
    end
    hen[0] = en; hd[0] = d; hsel[0] = sel;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nassert++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] aq, eq;
    logic [3:0]  au, ap, ao;
    for (int m = 0; m < 3; m++) begin
      case (m)
        0: begin aq = if0.q; au = if0.upd; ap = if0.pend; ao = if0.ovf; end
        1: begin aq = if1.q; au = if1.upd; ap = if1.pend; ao = if1.ovf; end
        default: begin
          aq = {8'h00, if2.q}; au = {1'b0, if2.upd}; ap = {1'b0, if2.pend}; ao = {1'b0, if2.ovf};
        end
      endcase
      eq = {mq[m][3], mq[m][2], mq[m][1], mq[m][0]};
      chk($sformatf("q_inst%0d", m),    aq, eq);
      chk($sformatf("upd_inst%0d", m),  {28'h0, au}, {28'h0, mupd[m]});
      chk($sformatf("pend_inst%0d", m), {28'h0, ap}, {28'h0, mpend[m]});
      chk($sformatf("ovf_inst%0d", m),  {28'h0, ao}, {28'h0, movf[m]});
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
    end
  endtask

  initial begin
    model_reset();
    // Reset held with an active-looking strobe
    #2;
    rstn = 1'b0; model_reset();
    d = 8'hFF; en = 1'b1; sel = 2'd3;
    tick(3);
    chk("reset_q", if0.q, 32'h0);
    chk("reset_flags", {20'h0, if0.upd, if0.pend, if0.ovf}, 32'h0);
    en = 1'b0; d = 8'h00; sel = 2'd0;
    rstn = 1'b1;
    tick(3);

    // Edge capture, data change while strobe held high
    sel = 2'd2; d = 8'hA5; en = 1'b1;
    tick(3);
    chk("edge_q2", {24'h0, if0.q[23:16]}, 32'hA5);
    chk("edge_upd", {28'h0, if0.upd}, 32'h4);
    d = 8'h5A;
    tick(3);
    en = 1'b0;
    tick(3);
    chk("edge_hold", if0.q, 32'h00A5_0000);
    chk("edge_pend", {28'h0, if0.pend}, 32'h4);
    ack = 4'hF; tick(); ack = 4'h0; tick();

    // Overflow from two unacknowledged pulses
    sel = 2'd1; d = 8'h11; en = 1'b1; tick(); en = 1'b0; tick(3);
    d = 8'h22; en = 1'b1; tick(); en = 1'b0; tick(3);
    chk("ovf_q1", {24'h0, if0.q[15:8]}, 32'h22);
    chk("ovf_pend", {31'h0, if0.pend[1]}, 32'h1);
    chk("ovf_set", {31'h0, if0.ovf[1]}, 32'h1);
    ack = 4'b0010; tick(); ack = 4'h0; tick();
    chk("ack_pend", {31'h0, if0.pend[1]}, 32'h0);
    chk("ack_ovf_sticky", {31'h0, if0.ovf[1]}, 32'h1);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    chk("clr_q", if0.q, 32'h0);
    chk("clr_ovf", {28'h0, if0.ovf}, 32'h0);

    // Write and ack together, with pend already set, then with pend clear
    sel = 2'd0; d = 8'h01; en = 1'b1; tick(); en = 1'b0; tick(3);
    d = 8'h02; en = 1'b1; tick(); en = 1'b0; tick(); ack = 4'b0001; tick(); ack = 4'h0;
    chk("simul_pend", {31'h0, if0.pend[0]}, 32'h1);
    chk("simul_ovf", {31'h0, if0.ovf[0]}, 32'h0);
    chk("simul_q0", {24'h0, if0.q[7:0]}, 32'h02);
    ack = 4'b0001; tick(); ack = 4'h0; tick();
    d = 8'h03; en = 1'b1; tick(); en = 1'b0; tick(); ack = 4'b0001; tick(); ack = 4'h0;
    chk("simul_pend0_ovf", {31'h0, if0.ovf[0]}, 32'h0);
    chk("simul_pend0_pend", {31'h0, if0.pend[0]}, 32'h1);
    clr = 1'b1; tick(); clr = 1'b0; tick();

    // Clear colliding with a capture
    sel = 2'd3; d = 8'h77; en = 1'b1; tick(); en = 1'b0; tick(); clr = 1'b1; tick(); clr = 1'b0;
    chk("clrwin_q", if0.q, 32'h0);
    chk("clrwin_flags", {20'h0, if0.upd, if0.pend, if0.ovf}, 32'h0);
    tick();
    chk("clrwin_upd", {28'h0, if0.upd}, 32'h0);
    tick(2);

    // Level mode burst on channel 3
    sel = 2'd3; d = 8'd1; en = 1'b1; tick();
    d = 8'd2; tick();
    d = 8'd3; tick();
    chk("level_step1", {24'h0, if1.q[31:24]}, 32'd1);
    d = 8'd4; tick();
    chk("level_step2", {24'h0, if1.q[31:24]}, 32'd2);
    en = 1'b0; tick(2);
    chk("level_last", {24'h0, if1.q[31:24]}, 32'd4);
    chk("level_upd", {28'h0, if1.upd}, 32'h8);
    chk("level_pend", {28'h0, if1.pend}, 32'h8);
    chk("level_ovf", {28'h0, if1.ovf}, 32'h0);
    tick();
    chk("level_upd_end", {28'h0, if1.upd}, 32'h0);
    tick(2);
    chk("level_holds", {24'h0, if1.q[31:24]}, 32'd4);
    chk("sel_oob_q", {8'h0, if2.q}, 32'h0);
    chk("sel_oob_pend", {29'h0, if2.pend}, 32'h0);

    // Reset released with the strobe already high
    rstn = 1'b0; model_reset();
    sel = 2'd0; d = 8'h3C; en = 1'b1;
    tick();
    rstn = 1'b1;
    tick(2);
    chk("rel_before", {24'h0, if0.q[7:0]}, 32'h0);
    tick();
    chk("rel_capture", {24'h0, if0.q[7:0]}, 32'h3C);
    chk("rel_upd", {28'h0, if0.upd}, 32'h1);
    d = 8'hC3;
    tick(4);
    chk("rel_once", {24'h0, if0.q[7:0]}, 32'h3C);
    chk("rel_upd_quiet", {28'h0, if0.upd}, 32'h0);
    en = 1'b0; tick(2);

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) en = ~en;
      d   = 8'($urandom);
      sel = 2'($urandom_range(0, 3));
      ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      clr = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
